// File: rtl/rr_decode_scheduler_pkg.sv
// Shared types and helpers for the round-robin decode scheduler.
// Holds the state encoding, requester-count constants and the
// rotating find-first search used to pick the next winner.
package rr_sched_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } sched_state_t;

    // First set bit of vec, scanning upward from start and wrapping
    // from N_REQ-1 back to 0. Returns 0 when vec is empty; callers
    // check for an empty vector themselves.
    function automatic logic [IDX_W-1:0] rr_find_first(
        input logic [N_REQ-1:0] vec,
        input logic [IDX_W-1:0] start
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + IDX_W'(i);
            if (!found && vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_decode_scheduler_if.sv
// Requester/grant bundle between the requesters and the scheduler.
// The master side drives enable and requests; the scheduler (slave)
// returns the one-hot grant, winner index and status flags.
interface rr_decode_scheduler_if;
    import rr_sched_pkg::*;

    logic              en_i;
    logic [N_REQ-1:0]  req_i;
    logic [N_REQ-1:0]  gnt_o;
    logic [IDX_W-1:0]  gnt_idx_o;
    logic              gnt_valid_o;
    logic              busy_o;
    logic              timeout_o;

    modport master (
        output en_i, req_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o, busy_o, timeout_o
    );

    modport slave (
        input  en_i, req_i,
        output gnt_o, gnt_idx_o, gnt_valid_o, busy_o, timeout_o
    );

endinterface

// File: rtl/rr_decode_scheduler_onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with an enable; all outputs
// are zero while the enable is low.
module onehot_dec3to8
    import rr_sched_pkg::*;
(
    input  logic              en_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [N_REQ-1:0]  onehot_o
);

    // Decode the index into a single set bit when enabled
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_scheduler.sv
// Round-robin scheduler sharing one 8-way one-hot select among 8
// requesters. A winner keeps the grant while it requests; releasing
// inserts one dead GAP cycle before the next owner is granted.
// Optional macro SCHED_TIMEOUT_EN: adds a hold counter that forcibly
// revokes a grant after MAX_HOLD cycles and pulses timeout_o.
module rr_decode_scheduler
    import rr_sched_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    rr_decode_scheduler_if.slave  bus
);

    // Reject parameter sets the hold counter cannot represent
    if ((MAX_HOLD < 2) || (MAX_HOLD > 31) || ((2 ** HOLD_W) <= MAX_HOLD)) begin : g_bad_param
        $error("rr_decode_scheduler: MAX_HOLD must be 2..31 and fit in HOLD_W bits");
    end

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]  last_idx_q, last_idx_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  win_idx;

`ifdef SCHED_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    // Candidate winner: rotate priority so the previous owner is last
    always_comb begin
        win_idx = rr_find_first(bus.req_i, last_idx_q + IDX_W'(1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
`ifdef SCHED_TIMEOUT_EN
        hold_d     = hold_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (bus.en_i && (|bus.req_i)) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = win_idx;
`ifdef SCHED_TIMEOUT_EN
                    hold_d    = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!bus.req_i[gnt_idx_q]) begin
                    // Voluntary release wins over a coincident timeout
                    state_d    = ST_GAP;
                    last_idx_d = gnt_idx_q;
`ifdef SCHED_TIMEOUT_EN
                    hold_d     = '0;
`endif
                end
`ifdef SCHED_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d    = ST_GAP;
                    last_idx_d = gnt_idx_q;
                    hold_d     = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gnt_valid_d = (state_d == ST_GRANT);
        busy_d      = (state_d == ST_GRANT) || (state_d == ST_GAP);
    end

    onehot_dec3to8 u_dec (
        .en_i     (gnt_valid_d),
        .idx_i    (gnt_idx_d),
        .onehot_o (gnt_d)
    );

    // State and registered outputs; reset clears the grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_idx_q   <= '0;
            last_idx_q  <= IDX_W'(N_REQ - 1);
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            last_idx_q  <= last_idx_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    // Hold counter and forced-revoke pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_idx_o   = gnt_idx_q;
    assign bus.gnt_valid_o = gnt_valid_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_rr_decode_scheduler.sv
// Self-checking bench for rr_decode_scheduler: directed scenarios
// followed by random traffic, all checked against an owner/gap
// reference model. Honours SCHED_TIMEOUT_EN when defined.
module tb_rr_decode_scheduler;

    localparam int TB_MAX_HOLD = 4;
`ifdef SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference model: current owner (-1 none), last owner, last index,
    // cycles held, whether this cycle is the dead gap, timeout pulse.
    int   m_owner;
    int   m_last;
    int   m_idx;
    int   m_hold;
    bit   m_gap;
    bit   m_to;

    rr_decode_scheduler_if bus();

    rr_decode_scheduler #(
        .MAX_HOLD (TB_MAX_HOLD),
        .HOLD_W   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_idx   = 0;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] req);
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
                m_hold  = 0;
            end else if (TO_EN && (m_hold == TB_MAX_HOLD - 1)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
                m_hold  = 0;
                m_to    = 1'b1;
            end else begin
                m_hold++;
            end
        end else begin
            m_gap = 1'b0;
            if (en && (req != 8'h00)) begin
                for (int k = 1; k <= 8; k++) begin
                    int c;
                    c = (m_last + k) % 8;
                    if (req[c]) begin
                        m_owner = c;
                        m_idx   = c;
                        m_hold  = 0;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, ".gnt"},     bus.gnt_o, e_gnt);
        chk({tag, ".idx"},     bus.gnt_idx_o, m_idx);
        chk({tag, ".valid"},   bus.gnt_valid_o, (m_owner >= 0) ? 1 : 0);
        chk({tag, ".busy"},    bus.busy_o, ((m_owner >= 0) || m_gap) ? 1 : 0);
        chk({tag, ".timeout"}, bus.timeout_o, m_to);
        chk({tag, ".onehot0"}, $onehot0(bus.gnt_o), 1);
    endtask

    // Apply inputs, let one rising edge pass, then check 1 time unit later
    task automatic cycle(input logic en, input logic [7:0] req, input string tag);
        bus.en_i  = en;
        bus.req_i = req;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(en, req);
        #1;
        check_all(tag);
    endtask

    // Asserts reset mid-cycle (checks the asynchronous clear), holds it
    // for two edges with req_during applied, then releases it.
    task automatic do_reset(input logic [7:0] req_during);
        bus.en_i  = 1'b1;
        bus.req_i = req_during;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset_async");
        cycle(1'b1, req_during, "reset_hold");
        cycle(1'b1, req_during, "reset_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        int          gcnt;
        int          nwin;
        int          n_to;
        logic        prev_valid;
        logic [7:0]  r;
        logic [7:0]  r2;
        logic        e;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.en_i  = 1'b0;
        bus.req_i = 8'h00;
        model_reset();
        #1;

        // Reset values, idle, then first request with one-cycle latency
        do_reset(8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00, "idle");
        chk("idle_idx", bus.gnt_idx_o, 0);
        cycle(1'b1, 8'h01, "first_req");
        chk("first_gnt", bus.gnt_o, 8'h01);

        // All requesting, each winner holds 3 cycles then releases
        do_reset(8'h00);
        gcnt = 0;
        nwin = 0;
        prev_valid = 1'b0;
        r = 8'hFF;
        for (int i = 0; i < 60 && nwin < 9; i++) begin
            cycle(1'b1, r, "rr_all");
            if (bus.gnt_valid_o && !prev_valid) begin
                chk("rr_order", bus.gnt_idx_o, nwin % 8);
                nwin++;
            end
            prev_valid = bus.gnt_valid_o;
            if (m_owner >= 0) gcnt++;
            else              gcnt = 0;
            r = ((m_owner >= 0) && (gcnt == 3)) ? (8'hFF & ~(8'd1 << m_owner)) : 8'hFF;
        end
        chk("rr_count", nwin, 9);

        // Wrap-around: last owner 6, requests 0 and 6 -> 0 wins, then 6
        do_reset(8'h00);
        cycle(1'b1, 8'h40, "wrap_setup");
        chk("wrap_setup_gnt", bus.gnt_o, 8'h40);
        cycle(1'b1, 8'h00, "wrap_rel");
        cycle(1'b1, 8'h00, "wrap_idle");
        cycle(1'b1, 8'h41, "wrap_win0");
        chk("wrap_idx0", bus.gnt_idx_o, 0);
        cycle(1'b1, 8'h40, "wrap_gap");
        chk("wrap_gap_gnt", bus.gnt_o, 8'h00);
        cycle(1'b1, 8'h40, "wrap_win6");
        chk("wrap_idx6", bus.gnt_idx_o, 6);

        // Enable low does not cut an active grant but blocks new ones
        do_reset(8'h00);
        cycle(1'b1, 8'h08, "en_grant");
        chk("en_grant_gnt", bus.gnt_o, 8'h08);
        cycle(1'b0, 8'h08, "en_hold");
        cycle(1'b0, 8'h08, "en_hold");
        chk("en_hold_gnt", bus.gnt_o, 8'h08);
        cycle(1'b0, 8'h00, "en_rel");
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h08, "en_blocked");
        chk("en_blocked_busy", bus.busy_o, 0);
        cycle(1'b1, 8'h08, "en_raise");
        chk("en_raise_gnt", bus.gnt_o, 8'h08);

        // Reset in the middle of a grant
        do_reset(8'h00);
        cycle(1'b1, 8'h10, "mid_grant");
        cycle(1'b1, 8'h10, "mid_grant");
        chk("mid_grant_gnt", bus.gnt_o, 8'h10);
        do_reset(8'h10);
        cycle(1'b1, 8'h10, "post_reset");
        chk("post_reset_gnt", bus.gnt_o, 8'h10);

        // Steady requests on 1 and 2: timeout rotation or indefinite hold
        do_reset(8'h00);
        n_to = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 8'h06, "steady");
            if (bus.timeout_o === 1'b1) n_to++;
            if (i == 3) chk("steady_idx_first", bus.gnt_idx_o, 1);
            if (i == 5) chk("steady_idx_next", bus.gnt_idx_o, TO_EN ? 2 : 1);
        end
        chk("steady_timeouts", n_to, TO_EN ? 2 : 0);

        // Random traffic against the model
        do_reset(8'h00);
        for (int i = 0; i < 400; i++) begin
            r  = 8'($urandom);
            r2 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & r2;
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            e  = ($urandom_range(0, 5) != 0);
            cycle(e, r, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_decode_scheduler.md
Name: rr_decode_scheduler

Overview:
- Round-robin scheduler that shares one 8-way one-hot select resource among 8 requesters.
- Picks a winning 3-bit index, holds it while the winner keeps requesting, then rotates priority.
- Drives the index through a 3-to-8 one-hot decode sub-module to produce grant lines for the downstream mux/enable fabric.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per winner; used only when SCHED_TIMEOUT_EN is defined; legal range 2..31.
- HOLD_W, 5, width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_i  input  1  arbitration enable; low blocks new grants and does not affect a grant already in progress.
- req_i  input  8  request vector; bit k is requester k.
- gnt_o  output  8  one-hot grant; all-zero when no grant is active.
- gnt_idx_o  output  3  index of the current or most recent winner.
- gnt_valid_o  output  1  high in GRANT state.
- busy_o  output  1  high in GRANT or GAP state.
- timeout_o  output  1  one-cycle pulse on forced revoke; tied 0 without SCHED_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - state=IDLE, gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, busy_o=0, timeout_o=0.
  - last_idx=7, so the first search starts at index 0. hold_cnt=0.
- States (2-bit encoding): IDLE=2'b00, GRANT=2'b01, GAP=2'b10. 2'b11 is illegal and recovers to IDLE on the next clock.
- Search (IDLE and GAP):
  - If en_i=1 and req_i!=0, the winner is the first set bit scanning from (last_idx+1) mod 8 upward, wrapping 7->0.
  - Register the winner into gnt_idx_o and go to GRANT. Latency is 1 cycle from sampled request to gnt_o asserted.
  - If en_i=0 or req_i==0: IDLE stays in IDLE; GAP goes to IDLE.
- GRANT:
  - gnt_o=decode(gnt_idx_o), all-registered outputs, gnt_valid_o=1, hold_cnt increments each cycle.
  - The winner releases by dropping req_i[gnt_idx_o]. When it is sampled low: last_idx<=gnt_idx_o, hold_cnt<=0, go to GAP.
  - Other requesters' bits are ignored while in GRANT.
- GAP:
  - Exactly one dead cycle with gnt_o=0 and gnt_valid_o=0, so no back-to-back overlap between owners.
  - Arbitration runs in this cycle, so release at cycle t gives GAP at t+1 and the new grant at t+2.
- Simultaneous events: a requester that releases and re-raises across the GAP is lowest priority. If it is the only requester, it wins again.
- Only one gnt_o bit may be high in any cycle. gnt_o must equal decode(gnt_idx_o) whenever gnt_valid_o=1.
- Reset mid-grant drops gnt_o immediately (asynchronously) and restores the reset values above.
- gnt_idx_o holds its last value in IDLE and GAP.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt==MAX_HOLD-1 and the winner still requests, the grant is forcibly revoked.
  - timeout_o pulses for 1 cycle coincident with GAP entry, last_idx<=gnt_idx_o, and the state goes to GAP.
  - A voluntary release on the same cycle takes precedence: no timeout_o pulse.
- Undefined: the hold counter and compare logic are absent, timeout_o=0 constantly, and a grant lasts until release.

Decomposition:
- Package rr_sched_pkg holds:
  - the state typedef (IDLE/GRANT/GAP encodings);
  - constant N_REQ=8 and IDX_W=3;
  - the round-robin find-first function (vector, start index) returning index.
- One sub-module: onehot_dec3to8, a combinational 3-bit to 8-bit one-hot decode that outputs all zeros when its enable input is low.
- The scheduler instantiates it with enable=gnt_valid and registers the result.

Test Plan:
- After reset, req_i=8'h00 for 5 cycles -> gnt_o=0, busy_o=0, gnt_idx_o=0. Then req_i=8'h01 -> gnt_o=8'h01 one cycle later.
- req_i=8'hFF, each winner holds 3 cycles then releases and re-raises -> grant order 0,1,2,...,7,0 with one GAP cycle between owners.
- last_idx=6 and req_i=8'h41 -> winner index 0 through wrap-around (scan order 7,0). Then with only bit 6 requesting after release -> winner 6.
- Hold grant on index 3, drop en_i, then release -> gnt_o=0 and state stays IDLE while en_i=0. Raise en_i -> grant within 1 cycle.
- Assert rst_n=0 mid-grant (gnt_o=8'h10) -> gnt_o=0 asynchronously. After release from reset with req_i=8'h10 -> gnt_o=8'h10 one cycle later.
- SCHED_TIMEOUT_EN, MAX_HOLD=4, req_i=8'h06 held steady:
  - index 1 is granted for 4 cycles, then timeout_o pulses with GAP;
  - index 2 is granted next;
  - the undefined build keeps index 1 granted indefinitely.
